// File: rtl/icc_mailbox_fifo.sv
// icc_mailbox_fifo: inter-core mailbox FIFO between a sender stream master and
// a receiver stream slave. First-word-fall-through head, registered s_ready /
// m_valid / level, and a sticky interrupt raised on a fill threshold.
// Optional feature macro: ICC_MAILBOX_TIMEOUT_EN adds an idle-timeout source
// for the interrupt (data pending with no transfer for TIMEOUT_CYCLES cycles).
module icc_mailbox_fifo #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 16,
  parameter int IRQ_THRESHOLD  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     irq,
  input  logic                     irq_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] THR_LVL  = LVL_W'(IRQ_THRESHOLD);

  // Reject configurations the pointer/level arithmetic cannot represent.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || IRQ_THRESHOLD < 1 ||
      IRQ_THRESHOLD > DEPTH || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("icc_mailbox_fifo: illegal parameter combination");
  end

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PENDING = 1'b1
  } irq_state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  irq_state_e       irq_state_q, irq_state_d;
  logic             wr_acc;
  logic             rd_acc;
  logic             irq_set;
  logic             timeout_fire;

  // Accepted transfers and next pointer/occupancy; flags derive from level only.
  always_comb begin
    wr_acc    = s_valid & s_ready_q;
    rd_acc    = m_valid_q & m_ready;
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d  = rd_ptr_q + PTR_W'(rd_acc);
    level_d   = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
    s_ready_d = (level_d < FULL_LVL);
    m_valid_d = (level_d != '0);
  end

  // Storage array; never reset, a reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef ICC_MAILBOX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Idle counter: cleared by traffic or an empty FIFO, saturates so it fires once.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (wr_acc || rd_acc || (level_q == '0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TO_MAX) begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end
    timeout_fire = (idle_cnt_d == TO_MAX) && (idle_cnt_q != TO_MAX);
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Interrupt state: a set condition overrides an acknowledge in the same cycle.
  always_comb begin
    irq_set     = (level_d >= THR_LVL) || timeout_fire;
    irq_state_d = irq_state_q;
    case (irq_state_q)
      IRQ_IDLE:    if (irq_set)              irq_state_d = IRQ_PENDING;
      IRQ_PENDING: if (irq_ack && !irq_set)  irq_state_d = IRQ_IDLE;
      default:                               irq_state_d = IRQ_IDLE;
    endcase
  end

  // Control and status registers; s_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      irq_state_q <= IRQ_IDLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      irq_state_q <= irq_state_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign level   = level_q;
  assign m_data  = mem_q[rd_ptr_q];
  assign irq     = (irq_state_q == IRQ_PENDING);

endmodule

// File: tb/tb_icc_mailbox_fifo.sv
// Bench for icc_mailbox_fifo: queue-based reference model, scenario tasks.
module tb_icc_mailbox_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int THR   = 8;
  localparam int TMO   = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [4:0]       level;
  logic             irq;
  logic             irq_ack = 1'b0;

  icc_mailbox_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .IRQ_THRESHOLD(THR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  bit               m_rdy = 1'b0;
  bit               m_irq = 1'b0;
  int               m_idle = 0;

  logic [7:0] dut_stat;
  assign dut_stat = {s_ready, m_valid, level, irq};

  function automatic logic [7:0] exp_stat();
    logic [4:0] l;
    l = 5'(mq.size());
    return {m_rdy, (mq.size() != 0), l, m_irq};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rdy  = 1'b0;
    m_irq  = 1'b0;
    m_idle = 0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic step(input bit sv, input logic [WIDTH-1:0] d, input bit mr, input bit ack);
    bit wr, rd, fire;
    s_valid = sv; s_data = d; m_ready = mr; irq_ack = ack;
    @(posedge clk);
    wr   = sv && m_rdy;
    rd   = mr && (mq.size() != 0);
    fire = 1'b0;
`ifdef ICC_MAILBOX_TIMEOUT_EN
    if (wr || rd || mq.size() == 0) m_idle = 0;
    else if (m_idle < TMO) begin
      m_idle++;
      fire = (m_idle == TMO);
    end
`endif
    if (rd) void'(mq.pop_front());
    if (wr) mq.push_back(d);
    m_rdy = (mq.size() < DEPTH);
    if (mq.size() >= THR || fire) m_irq = 1'b1;
    else if (ack)                 m_irq = 1'b0;
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0;
    #12;
    total++;
    if (dut_stat !== 8'h00) $display("FAIL reset_state got %h want 00", dut_stat);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (s_ready !== 1'b0) $display("FAIL ready_before_edge got %b want 0", s_ready);
    else passes++;
    @(negedge clk);
    step(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (dut_stat !== exp_stat() || s_ready !== 1'b1)
      $display("FAIL ready_after_release got %h want %h", dut_stat, exp_stat());
    else passes++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 32'h1000 + i, 1'b0, 1'b0);
      total++;
      if (dut_stat !== exp_stat() || level !== 5'(i + 1) || irq !== (i + 1 >= THR))
        $display("FAIL fill_%0d got %h want %h", i, dut_stat, exp_stat());
      else passes++;
    end
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    total++;
    if (dut_stat !== exp_stat() || level !== 5'd16 || s_ready !== 1'b0)
      $display("FAIL fill_overflow got %h want %h", dut_stat, exp_stat());
    else passes++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== mq[0] || m_data !== 32'h1000 + i)
        $display("FAIL drain_%0d got %h want %h", i, m_data, 32'h1000 + i);
      else passes++;
      step(1'b0, '0, 1'b1, 1'b0);
    end
    total++;
    if (dut_stat !== exp_stat() || m_valid !== 1'b0 || level !== 5'd0)
      $display("FAIL drain_empty got %h want %h", dut_stat, exp_stat());
    else passes++;
    step(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (dut_stat !== exp_stat())
      $display("FAIL read_when_empty got %h want %h", dut_stat, exp_stat());
    else passes++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== mq[0])
        $display("FAIL stream_data_%0d got %h want %h", i, m_data, mq[0]);
      else passes++;
      step(1'b1, $urandom, 1'b1, 1'b0);
      total++;
      if (dut_stat !== exp_stat() || level !== 5'd3)
        $display("FAIL stream_level_%0d got %h want %h", i, dut_stat, exp_stat());
      else passes++;
    end
  endtask

  task automatic test_irq();
    step(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (irq !== 1'b0 || dut_stat !== exp_stat())
      $display("FAIL irq_ack_low got %h want %h", dut_stat, exp_stat());
    else passes++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      total++;
      if (dut_stat !== exp_stat())
        $display("FAIL irq_rise_%0d got %h want %h", i, dut_stat, exp_stat());
      else passes++;
    end
    step(1'b1, $urandom, 1'b0, 1'b1);
    total++;
    if (irq !== 1'b1 || dut_stat !== exp_stat())
      $display("FAIL irq_ack_collision got %h want %h", dut_stat, exp_stat());
    else passes++;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (irq !== 1'b1 || level !== 5'd5 || dut_stat !== exp_stat())
      $display("FAIL irq_sticky got %h want %h", dut_stat, exp_stat());
    else passes++;
    step(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (irq !== 1'b0 || dut_stat !== exp_stat())
      $display("FAIL irq_clean_ack got %h want %h", dut_stat, exp_stat());
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      total++;
      if (mq.size() != 0 && m_data !== mq[0])
        $display("FAIL random_data_%0d got %h want %h", i, m_data, mq[0]);
      else passes++;
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0);
      total++;
      if (dut_stat !== exp_stat())
        $display("FAIL random_stat_%0d got %h want %h", i, dut_stat, exp_stat());
      else passes++;
    end
  endtask

`ifdef ICC_MAILBOX_TIMEOUT_EN
  task automatic test_timeout();
    while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, $urandom, 1'b0, 1'b0);
    for (int k = 1; k <= 260; k++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      total++;
      if (irq !== (k >= TMO) || dut_stat !== exp_stat())
        $display("FAIL timeout_%0d got %h want %h", k, dut_stat, exp_stat());
      else passes++;
    end
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) step(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (irq !== 1'b0 || dut_stat !== exp_stat())
      $display("FAIL timeout_no_refire got %h want %h", dut_stat, exp_stat());
    else passes++;
    step(1'b1, $urandom, 1'b0, 1'b0);
    for (int k = 1; k <= TMO; k++) step(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (irq !== 1'b1 || dut_stat !== exp_stat())
      $display("FAIL timeout_rearm got %h want %h", dut_stat, exp_stat());
    else passes++;
  endtask
`endif

  task automatic test_mid_reset();
    while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    total++;
    if (irq !== 1'b1 || level !== 5'd10 || dut_stat !== exp_stat())
      $display("FAIL pre_reset got %h want %h", dut_stat, exp_stat());
    else passes++;
    #3 rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_stat !== 8'h00)
      $display("FAIL async_reset got %h want 00", dut_stat);
    else passes++;
    #33 rst = 1'b1;
    @(negedge clk);
    total++;
    if (dut_stat !== exp_stat())
      $display("FAIL reset_held got %h want %h", dut_stat, exp_stat());
    else passes++;
    step(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (dut_stat !== exp_stat() || m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL post_reset_empty got %h want %h", dut_stat, exp_stat());
    else passes++;
    step(1'b1, 32'hABCD_0001, 1'b0, 1'b0);
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'hABCD_0001 || dut_stat !== exp_stat())
      $display("FAIL post_reset_data got %h want abcd0001", m_data);
    else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_irq();
    test_random();
`ifdef ICC_MAILBOX_TIMEOUT_EN
    test_timeout();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
